addsub_seq: RTL and testbench

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_seq_if.sv | 28 ++
 rtl/addsub_seq.sv | 111 +++++++++++
 tb/tb_addsub_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_if.sv
// Handshake bundle for addsub_seq: operand channel (in_*) and result channel (out_*).
// The master drives operands and out_ready; the slave (the adder) returns results and flags.
interface addsub_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, mode, cin, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, mode, cin, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_seq.sv
// Slice-serial adder/subtractor: SLICE bits per cycle, result after WIDTH/SLICE cycles.
// IDLE accepts an operation, RUN ripples the carry slice by slice, DONE holds until out_ready.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_seq_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [SLICE-1:0] w_a_sl [NSLICE];
  logic [SLICE-1:0] w_b_sl [NSLICE];
  logic [SLICE:0]   w_sum;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Split operands into slices; the current slice's sum is merged into the result image.
  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign w_a_sl[gi] = r_a[gi*SLICE +: SLICE];
      assign w_b_sl[gi] = r_b[gi*SLICE +: SLICE];
      assign w_res_next[gi*SLICE +: SLICE] = (r_cnt == CNT_W'(gi)) ? w_sum[SLICE-1:0]
                                                                   : r_result[gi*SLICE +: SLICE];
    end
  endgenerate

  assign w_sum  = {1'b0, w_a_sl[r_cnt]} + {1'b0, w_b_sl[r_cnt]} + {{SLICE{1'b0}}, r_carry};
  assign w_last = (r_cnt == CNT_W'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is a + ~b + 1, so invert b once here and seed the carry with 1.
            r_a        <= bus.a;
            r_b        <= bus.mode ? ~bus.b : bus.b;
            r_carry    <= bus.mode ? 1'b1 : bus.cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_res_next;
          r_carry  <= w_sum[SLICE];
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_cout      <= w_sum[SLICE];
            r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
            r_zero      <= (w_res_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq (WIDTH=32, SLICE=4): directed corner vectors,
// backpressure, mid-run reset and randomized operations checked against an arithmetic model.
module tb_addsub_seq;
  localparam int  W   = 32;
  localparam int  S   = 4;
  localparam int  LAT = W / S;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  bit   forced_ready = 1'b0;
  bit   prev_ov = 1'b0;
  exp_t q[$];

  addsub_seq_if #(.WIDTH(W)) bus ();

  addsub_seq #(.WIDTH(W), .SLICE(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : forced_ready;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic m, input logic c);
    exp_t       e;
    logic [W:0] s;
    longint     t;
    if (m) begin
      s    = {1'b0, a} - {1'b0, b};
      e.co = (a >= b);
      t    = longint'($signed(a)) - longint'($signed(b));
    end else begin
      s    = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      e.co = s[W];
      t    = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    end
    e.res = s[W-1:0];
    e.ov  = (t > SMAX) || (t < SMIN);
    e.z   = (e.res == '0);
    e.acc = 0;
    return e;
  endfunction

  // Called at 1 time unit after a rising edge; returns at the same phase after the accept edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input logic c);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.a        = a;
    bus.b        = b;
    bus.mode     = m;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    e     = model(a, b, m, c);
    e.acc = cyc;
    q.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: latency on each rising out_valid, full compare on each output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_ov) begin
        if (q.size() == 0) chk("valid_without_op", 64'd1, 64'd0);
        else               chk("latency", 64'(cyc - q[0].acc), 64'(LAT));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", 64'(bus.result), 64'(e.res));
          chk("cout",   64'(bus.cout),   64'(e.co));
          chk("ovf",    64'(bus.ovf),    64'(e.ov));
          chk("zero",   64'(bus.zero),   64'(e.z));
        end
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  initial begin
    exp_t bp;
    bit   saw_valid;
    int   n;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.mode     = 1'b0;
    bus.cin      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'(bus.result),    64'd0);
    chk("rst_flags",     64'({bus.cout, bus.ovf, bus.zero}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    forced_ready = 1'b1;
    do_op(32'd5, 32'd3, 1'b1, 1'b0);
    do_op(32'd3, 32'd5, 1'b1, 1'b1);
    do_op(32'h8000_0000, 32'd1, 1'b1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1);
    drain();

    // Backpressure: hold out_ready low in DONE while the operand inputs churn.
    forced_ready = 1'b0;
    bp = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.mode     = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("bp_hold_result", 64'(bus.result), 64'(bp.res));
      chk("bp_hold_flags",  64'({bus.cout, bus.ovf, bus.zero}), 64'({bp.co, bp.ov, bp.z}));
      chk("bp_in_ready",    64'({bus.in_ready, bus.out_valid}), 64'b01);
    end
    bus.in_valid = 1'b0;
    forced_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    @(posedge clk);
    #1;

    // Reset during RUN cycle 4 discards the operation.
    do_op(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", 64'(bus.result), 64'd0);
    chk("mid_rst_flags",  64'({bus.cout, bus.ovf, bus.zero}), 64'd0);
    chk("mid_rst_hs",     64'({bus.in_ready, bus.out_valid}), 64'b10);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    chk("no_valid_after_rst", 64'(saw_valid), 64'd0);
    @(posedge clk);
    #1;
    do_op(32'd10, 32'd10, 1'b1, 1'b0);
    drain();

    // Randomized traffic with random output backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 3) rb = ra;
      if (i % 8 == 5) ra = ~rb;
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
